// File: rtl/inst_fetch_buf.sv
// Instruction prefetch buffer: issues sequential word fetches, queues {inst, addr}
// in a DEPTH-entry FIFO for the core, and flushes/restarts on a core redirect.
module inst_fetch_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_af   [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_af_rd_ptr;
  logic [AW-1:0] r_af_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;

  logic [CW:0]   w_credit;
  logic          w_issue;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_unused_lsb;

  assign w_unused_lsb = redirect_addr_i[1:0];

  // Queued plus in-flight words may never exceed the FIFO size, so a response always has a slot.
  assign w_credit     = {1'b0, r_count} + {1'b0, r_inflight};
  assign mem_req_o    = !redirect_i && (w_credit < (CW+1)'(DEPTH));
  assign mem_addr_o   = r_fetch_pc;
  assign w_issue      = mem_req_o && mem_gnt_i;
  assign w_resp       = mem_rvalid_i && (r_inflight != {CW{1'b0}});
  assign w_push       = w_resp && (r_drop == {CW{1'b0}}) && !redirect_i;
  assign w_pop        = inst_valid_o && inst_ready_i && !redirect_i;

  assign inst_valid_o = (r_count != {CW{1'b0}});
  assign inst_o       = inst_valid_o ? r_data[r_rd_ptr] : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? r_addr[r_rd_ptr] : 32'h0000_0000;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= {CW{1'b0}};
      r_inflight <= {CW{1'b0}};
      r_drop     <= {CW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
    end else if (redirect_i) begin
      // A response landing in the redirect cycle is already stale and is not counted as a drop.
      r_fetch_pc <= {redirect_addr_i[31:2], 2'b00};
      r_count    <= {CW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
      r_inflight <= r_inflight - CW'(w_resp);
      r_drop     <= r_inflight - CW'(w_resp);
    end else begin
      r_fetch_pc <= w_issue ? (r_fetch_pc + 32'd4) : r_fetch_pc;
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_resp);
      r_drop     <= (w_resp && (r_drop != {CW{1'b0}})) ? (r_drop - CW'(1)) : r_drop;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_wr_ptr   <= w_push ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
      r_rd_ptr   <= w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    end
  end

  // Issued-address FIFO survives redirects so stale responses still retire their entries.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_af_rd_ptr <= {AW{1'b0}};
      r_af_wr_ptr <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_af[i] <= 32'h0000_0000;
      end
    end else begin
      if (w_issue) begin
        r_af[r_af_wr_ptr] <= r_fetch_pc;
        r_af_wr_ptr       <= r_af_wr_ptr + AW'(1);
      end else begin
        r_af_wr_ptr <= r_af_wr_ptr;
      end
      r_af_rd_ptr <= w_resp ? (r_af_rd_ptr + AW'(1)) : r_af_rd_ptr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= 32'h0000_0000;
        r_addr[i] <= 32'h0000_0000;
      end
    end else if (w_push) begin
      r_data[r_wr_ptr] <= mem_rdata_i;
      r_addr[r_wr_ptr] <= r_af[r_af_rd_ptr];
    end else begin
      r_data[r_wr_ptr] <= r_data[r_wr_ptr];
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Bench for inst_fetch_buf: behavioural memory with configurable latency plus an
// expected-instruction scoreboard, a reset-time vector table and redirect/wrap sequences.
module tb_inst_fetch_buf;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = 32'h0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  inst_fetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_ready_i(inst_ready_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int unsigned due; logic [31:0] addr; bit stale; } pend_t;
  typedef struct {
    logic redirect; logic ready; logic gnt; logic rvalid;
    logic exp_req; logic exp_valid; logic [31:0] exp_inst; logic [31:0] exp_iaddr; logic [31:0] exp_maddr;
  } vec_t;

  pend_t       mq[$];
  logic [31:0] sb[$];
  logic [31:0] issued[$];
  int          m_count;
  logic [31:0] m_pc;
  int unsigned cyc;
  int unsigned lat;
  int          n_pass, n_total;
  int          grants, pops, first_grant;
  bit          head_seen;
  logic [31:0] first_head;
  int unsigned head_cyc, redir_cyc;
  vec_t        tbl[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: drive memory response, check at negedge, advance the model to the next edge.
  task automatic step();
    bit          rv;
    bit          exp_req;
    pend_t       p;
    int unsigned due;
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    mem_rvalid_i = rv;
    mem_rdata_i  = rv ? mem_word(mq[0].addr) : 32'hBAD0_BAD0;
    @(negedge clk_i);
    exp_req = !redirect_i && ((m_count + mq.size()) < DEPTH);
    check("mem_req", {31'b0, mem_req_o}, {31'b0, exp_req});
    check("mem_addr", mem_addr_o, m_pc);
    check("inst_valid", {31'b0, inst_valid_o}, {31'b0, m_count > 0});
    if (m_count > 0) begin
      check("inst_addr", inst_addr_o, sb[0]);
      check("inst_data", inst_o, mem_word(sb[0]));
    end else begin
      check("nop_inst", inst_o, NOP_INST);
      check("nop_addr", inst_addr_o, 32'h0);
    end
    if (inst_valid_o && !head_seen) begin
      head_seen  = 1'b1;
      first_head = inst_addr_o;
      head_cyc   = cyc;
    end
    if (redirect_i) begin
      sb.delete();
      m_count = 0;
      if (rv) void'(mq.pop_front());
      foreach (mq[i]) mq[i].stale = 1'b1;
      m_pc = {redirect_addr_i[31:2], 2'b00};
    end else begin
      if (m_count > 0 && inst_ready_i) begin
        void'(sb.pop_front());
        m_count--;
        pops++;
      end
      if (rv) begin
        p = mq.pop_front();
        if (!p.stale) m_count++;
      end
      if (mem_req_o && mem_gnt_i) begin
        due = cyc + lat;
        if (mq.size() > 0 && due <= mq[$].due) due = mq[$].due + 1;
        mq.push_back('{due: due, addr: mem_addr_o, stale: 1'b0});
        sb.push_back(m_pc);
        issued.push_back(mem_addr_o);
        grants++;
        if (first_grant < 0) first_grant = int'(cyc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    mem_rvalid_i = 1'b0;
    redirect_i = 1'b0;
    #1;
    check("rst_valid", {31'b0, inst_valid_o}, 32'h0);
    check("rst_inst", inst_o, NOP_INST);
    check("rst_iaddr", inst_addr_o, 32'h0);
    check("rst_maddr", mem_addr_o, RESET_PC);
    mq.delete();
    sb.delete();
    m_count = 0;
    m_pc = RESET_PC;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; lat = 1; m_count = 0; m_pc = RESET_PC;
    grants = 0; pops = 0; first_grant = -1; head_seen = 1'b0;

    // Reset-held vectors: outputs idle, request only gated by redirect.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, NOP_INST, 32'h0, RESET_PC};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP_INST, 32'h0, RESET_PC};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, NOP_INST, 32'h0, RESET_PC};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NOP_INST, 32'h0, RESET_PC};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, NOP_INST, 32'h0, RESET_PC};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NOP_INST, 32'h0, RESET_PC};
    for (int i = 0; i < 6; i++) begin
      redirect_i = tbl[i].redirect; redirect_addr_i = 32'h0000_0104;
      inst_ready_i = tbl[i].ready; mem_gnt_i = tbl[i].gnt;
      mem_rvalid_i = tbl[i].rvalid; mem_rdata_i = 32'hDEAD_BEEF;
      #2;
      check("tbl_req", {31'b0, mem_req_o}, {31'b0, tbl[i].exp_req});
      check("tbl_valid", {31'b0, inst_valid_o}, {31'b0, tbl[i].exp_valid});
      check("tbl_inst", inst_o, tbl[i].exp_inst);
      check("tbl_iaddr", inst_addr_o, tbl[i].exp_iaddr);
      check("tbl_maddr", mem_addr_o, tbl[i].exp_maddr);
    end
    redirect_i = 1'b0; mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0; inst_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // Streaming: single-cycle memory, core always ready.
    mem_gnt_i = 1'b1; inst_ready_i = 1'b1; lat = 1;
    for (int i = 0; i < 12; i++) step();
    check("first_valid_latency", head_cyc - first_grant, 32'd2);
    check("first_head_addr", first_head, RESET_PC);

    // Mid-stream reset, then back-pressure fills exactly DEPTH entries.
    do_reset();
    inst_ready_i = 1'b0; grants = 0; issued.delete();
    for (int i = 0; i < 8; i++) step();
    check("bp_grants", grants, 32'd4);
    check("bp_req_low", {31'b0, mem_req_o}, 32'h0);
    check("bp_last_issued", issued[3], 32'h0000_000C);
    check("bp_next_addr", mem_addr_o, 32'h0000_0010);
    inst_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Three-cycle memory latency with random core stalls.
    lat = 3; pops = 0;
    for (int i = 0; i < 40; i++) begin
      inst_ready_i = ($urandom_range(0, 3) != 0);
      check("inflight_bound", {31'b0, mq.size() <= DEPTH}, 32'h1);
      step();
    end
    check("lat3_throughput", {31'b0, pops >= 20}, 32'h1);

    // Redirect with words queued and in flight, response arriving in the same cycle.
    do_reset();
    inst_ready_i = 1'b0; lat = 3;
    for (int i = 0; i < 4; i++) step();
    check("pre_redirect_queued", {31'b0, inst_valid_o}, 32'h1);
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_0103; inst_ready_i = 1'b1;
    redir_cyc = cyc;
    step();
    redirect_i = 1'b0; lat = 1; head_seen = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("redir_head_addr", first_head, 32'h0000_0100);
    check("redir_head_latency", {31'b0, (head_cyc - redir_cyc) >= 3}, 32'h1);

    // Redirect coinciding with a response and a pop.
    check("redir_pop_rvalid", {31'b0, inst_valid_o && (mq.size() > 0) && (mq[0].due <= cyc)}, 32'h1);
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_0200;
    step();
    redirect_i = 1'b0; head_seen = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("redir2_head_addr", first_head, 32'h0000_0200);

    // Fetch address wraps past the top of the address space.
    redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFF9;
    step();
    redirect_i = 1'b0; issued.delete();
    for (int i = 0; i < 8; i++) step();
    check("wrap_issue_top", issued[1], 32'hFFFF_FFFC);
    check("wrap_issue_zero", issued[2], 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
